// File: rtl/mod_mem_responder.sv
// Word-addressed RAM slave with byte-masked writes and programmable wait states
// behind a waitrequest handshake; decode errors are acknowledged with error_o.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no transfer in flight, waitrequest high, request captured here
// WAIT  | counting down wait states; dropping the request aborts cleanly
// ACK   | waitrequest low for one cycle; readdatavalid/error pulses valid
module mod_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        read_i,
   input  logic        write_i,
   input  logic [31:0] address_i,
   input  logic [3:0]  byteenable_i,
   input  logic [31:0] writedata_i,
   output logic        waitrequest_o,
   output logic [31:0] readdata_o,
   output logic        readdatavalid_o,
   output logic        error_o
);

   localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   if (WAIT_CYCLES > 15) begin : g_chk_wait
      $error("mod_mem_responder: WAIT_CYCLES must be in 0..15");
   end
   if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_chk_depth
      $error("mod_mem_responder: DEPTH_WORDS must be a power of two >= 2");
   end
   if (BASE_ADDR[1:0] != 2'b00) begin : g_chk_base
      $error("mod_mem_responder: BASE_ADDR must be 4-byte aligned");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              waitrequest_q, waitrequest_d;
   logic [31:0]       readdata_q, readdata_d;
   logic              readdatavalid_q, readdatavalid_d;
   logic              error_q, error_d;

   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              bad_q, bad_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;

   logic [31:0]       mem_q [DEPTH_WORDS];
   logic              mem_we;
   logic              enter_ack;

   logic              req;
   logic              below_base;
   logic [31:0]       offset;
   logic              in_bad;

   assign req = read_i | write_i;

   // Borrow out of the subtraction flags addresses below the window.
   assign {below_base, offset} = {1'b0, address_i} - {1'b0, BASE_ADDR};

   assign in_bad = (address_i[1:0] != 2'b00)
                 | below_base
                 | ({2'b00, offset[31:2]} >= DEPTH_WORDS)
                 | (read_i & write_i);

   // Request attributes track the bus while idle and freeze once a transfer starts.
   always_comb begin
      rd_d    = rd_q;
      wr_d    = wr_q;
      bad_d   = bad_q;
      idx_d   = idx_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      if (state_q == ST_IDLE) begin
         rd_d    = read_i;
         wr_d    = write_i;
         bad_d   = in_bad;
         idx_d   = offset[IDX_W+1:2];
         be_d    = byteenable_i;
         wdata_d = writedata_i;
      end
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      waitrequest_d   = 1'b1;
      readdata_d      = readdata_q;
      readdatavalid_d = 1'b0;
      error_d         = 1'b0;
      mem_we          = 1'b0;
      enter_ack       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               if (WAIT_CYCLES == 0) begin
                  enter_ack = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (!req) begin
               state_d = ST_IDLE;
            end else if (cnt_q == 4'd0) begin
               enter_ack = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (enter_ack) begin
         state_d         = ST_ACK;
         waitrequest_d   = 1'b0;
         error_d         = bad_d;
         readdatavalid_d = rd_d;
         if (rd_d) begin
            readdata_d = bad_d ? 32'h0 : mem_q[idx_d];
         end
         mem_we = wr_d & ~bad_d;
      end
   end

   // RAM contents survive reset; only an in-flight write is suppressed.
   always_ff @(posedge clk_i) begin
      if (!rst_i && mem_we) begin
         for (int n = 0; n < 4; n++) begin
            if (be_d[n]) begin
               mem_q[idx_d][8*n +: 8] <= wdata_d[8*n +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= ST_IDLE;
         cnt_q           <= 4'd0;
         waitrequest_q   <= 1'b1;
         readdata_q      <= 32'h0;
         readdatavalid_q <= 1'b0;
         error_q         <= 1'b0;
         rd_q            <= 1'b0;
         wr_q            <= 1'b0;
         bad_q           <= 1'b0;
         idx_q           <= '0;
         be_q            <= 4'h0;
         wdata_q         <= 32'h0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         waitrequest_q   <= waitrequest_d;
         readdata_q      <= readdata_d;
         readdatavalid_q <= readdatavalid_d;
         error_q         <= error_d;
         rd_q            <= rd_d;
         wr_q            <= wr_d;
         bad_q           <= bad_d;
         idx_q           <= idx_d;
         be_q            <= be_d;
         wdata_q         <= wdata_d;
      end
   end

   assign waitrequest_o   = waitrequest_q;
   assign readdata_o      = readdata_q;
   assign readdatavalid_o = readdatavalid_q;
   assign error_o         = error_q;

endmodule

// File: tb/tb_mod_mem_responder.sv
// Bench for mod_mem_responder: two instances (2 wait states at base 0, and
// zero wait states at a shifted base) driven against a word-array model.
module tb_mod_mem_responder;

   localparam int unsigned A_DEPTH = 1024;
   localparam int unsigned B_DEPTH = 16;
   localparam logic [31:0] B_BASE  = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;

   logic        a_rd, a_wr, a_wreq, a_rdv, a_err;
   logic [31:0] a_addr, a_wd, a_rdata;
   logic [3:0]  a_be;
   logic        b_rd, b_wr, b_wreq, b_rdv, b_err;
   logic [31:0] b_addr, b_wd, b_rdata;
   logic [3:0]  b_be;

   always #5 clk = ~clk;

   mod_mem_responder #(
      .DEPTH_WORDS (A_DEPTH),
      .WAIT_CYCLES (2),
      .BASE_ADDR   (32'h0)
   ) u_dut_a (
      .clk_i           (clk),
      .rst_i           (rst),
      .read_i          (a_rd),
      .write_i         (a_wr),
      .address_i       (a_addr),
      .byteenable_i    (a_be),
      .writedata_i     (a_wd),
      .waitrequest_o   (a_wreq),
      .readdata_o      (a_rdata),
      .readdatavalid_o (a_rdv),
      .error_o         (a_err)
   );

   mod_mem_responder #(
      .DEPTH_WORDS (B_DEPTH),
      .WAIT_CYCLES (0),
      .BASE_ADDR   (B_BASE)
   ) u_dut_b (
      .clk_i           (clk),
      .rst_i           (rst),
      .read_i          (b_rd),
      .write_i         (b_wr),
      .address_i       (b_addr),
      .byteenable_i    (b_be),
      .writedata_i     (b_wd),
      .waitrequest_o   (b_wreq),
      .readdata_o      (b_rdata),
      .readdatavalid_o (b_rdv),
      .error_o         (b_err)
   );

   typedef struct packed {
      logic        wreq;
      logic        rdv;
      logic        err;
      logic [31:0] rdata;
   } obs_t;

   int          n_checks = 0;
   int          n_pass   = 0;
   int unsigned wait_c [2] = '{2, 0};
   int unsigned depth  [2] = '{A_DEPTH, B_DEPTH};
   logic [31:0] base   [2] = '{32'h0, B_BASE};
   logic [31:0] mdl    [2][A_DEPTH];
   logic [31:0] last_rd [2];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
   endtask

   function automatic obs_t sample(input int s);
      obs_t o;
      if (s == 0) o = '{wreq: a_wreq, rdv: a_rdv, err: a_err, rdata: a_rdata};
      else        o = '{wreq: b_wreq, rdv: b_rdv, err: b_err, rdata: b_rdata};
      return o;
   endfunction

   task automatic drive(input int s, input logic rd, input logic wr, input logic [31:0] adr,
                        input logic [3:0] be, input logic [31:0] wd);
      if (s == 0) begin
         a_rd = rd; a_wr = wr; a_addr = adr; a_be = be; a_wd = wd;
      end else begin
         b_rd = rd; b_wr = wr; b_addr = adr; b_be = be; b_wd = wd;
      end
   endtask

   function automatic logic is_bad(input int s, input logic rd, input logic wr, input logic [31:0] adr);
      if (rd && wr)          return 1'b1;
      if (adr[1:0] != 2'b00) return 1'b1;
      if (adr < base[s])     return 1'b1;
      return ((adr - base[s]) / 4) >= depth[s];
   endfunction

   // Starts and ends on a falling edge. drop > 0 withdraws the request after
   // that many rising edges, which must land before the acknowledge.
   task automatic xfer(input string tag, input int s, input logic rd, input logic wr,
                       input logic [31:0] adr, input logic [3:0] be, input logic [31:0] wd,
                       input int drop);
      obs_t o;
      int   cyc;
      int   idx;
      logic early;
      logic bad;
      bad   = is_bad(s, rd, wr, adr);
      idx   = bad ? 0 : int'((adr - base[s]) >> 2);
      early = 1'b0;
      cyc   = 0;
      drive(s, rd, wr, adr, be, wd);
      if (drop > 0) begin
         repeat (drop) begin
            @(posedge clk); #1;
            o = sample(s);
            early |= ~o.wreq | o.rdv | o.err;
         end
         @(negedge clk);
         drive(s, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
         @(posedge clk); #1;
         o = sample(s);
         check_val({tag, "_abort_flags"}, {28'd0, early, o.wreq, o.rdv, o.err}, 32'h4);
         check_val({tag, "_abort_rdata"}, o.rdata, last_rd[s]);
         @(negedge clk);
         return;
      end
      do begin
         @(posedge clk); #1;
         cyc++;
         o = sample(s);
         if (o.wreq) early |= o.rdv | o.err;
      end while (o.wreq && cyc < 40);
      check_val({tag, "_lat"}, 32'(cyc), 32'(wait_c[s] + 1));
      if (rd) last_rd[s] = bad ? 32'h0 : mdl[s][idx];
      if (wr && !bad) begin
         for (int n = 0; n < 4; n++)
            if (be[n]) mdl[s][idx][8*n +: 8] = wd[8*n +: 8];
      end
      check_val({tag, "_flags"}, {28'd0, early, o.wreq, o.rdv, o.err}, {28'd0, 1'b0, 1'b0, rd, bad});
      check_val({tag, "_rdata"}, o.rdata, last_rd[s]);
      @(negedge clk);
      drive(s, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      @(posedge clk); #1;
      o = sample(s);
      check_val({tag, "_post"}, {29'd0, o.wreq, o.rdv, o.err}, 32'h4);
      @(negedge clk);
   endtask

   task automatic rand_xfer(input int s);
      int unsigned r, k, idx;
      logic [31:0] adr;
      logic        rd, wr;
      int          drop;
      r   = $urandom_range(0, 99);
      idx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : depth[s] - 1 - $urandom_range(0, 3);
      adr = base[s] + 32'(idx * 4);
      if (r >= 70 && r < 80)      adr = adr + 32'($urandom_range(1, 3));
      else if (r >= 80 && r < 90) adr = base[s] + 32'(depth[s] * 4) + 32'($urandom_range(0, 15) * 4);
      else if (r >= 90)           adr = base[s] - 32'($urandom_range(1, 8) * 4);
      k  = $urandom_range(0, 9);
      rd = (k <= 4);
      wr = (k == 0) || (k >= 5);
      drop = (s == 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      xfer("rnd", s, rd, wr, adr, 4'($urandom_range(0, 15)), $urandom, drop);
   endtask

   task automatic check_reset_outs(input string tag, input int s);
      obs_t o;
      o = sample(s);
      check_val({tag, "_flags"}, {29'd0, o.wreq, o.rdv, o.err}, 32'h4);
      check_val({tag, "_rdata"}, o.rdata, 32'h0);
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         last_rd[s] = 32'h0;
         for (int i = 0; i < int'(A_DEPTH); i++) mdl[s][i] = 32'h0;
      end
      rst = 1'b1;
      drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check_reset_outs("rst_a", 0);
      check_reset_outs("rst_b", 1);
      @(negedge clk);
      rst = 1'b0;

      xfer("t1_wr", 0, 1'b0, 1'b1, 32'h10, 4'hF, 32'hA1B2C3D4, 0);
      xfer("t1_rd", 0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 0);
      check_val("t1_val", a_rdata, 32'hA1B2C3D4);

      xfer("t2_sb", 0, 1'b0, 1'b1, 32'h20, 4'b0100, 32'h00EE0000, 0);
      xfer("t2_sh", 0, 1'b0, 1'b1, 32'h20, 4'b0011, 32'h00001234, 0);
      xfer("t2_rd", 0, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 0);
      check_val("t2_val", a_rdata, 32'h00EE1234);

      xfer("t3_mis", 0, 1'b1, 1'b0, 32'h22, 4'hF, 32'h0, 0);
      xfer("t3_rng", 0, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h0, 0);
      xfer("t3_rw",  0, 1'b1, 1'b1, 32'h0, 4'hF, 32'hDEADBEEF, 0);
      xfer("t3_wmis", 0, 1'b0, 1'b1, 32'h12, 4'hF, 32'hFFFFFFFF, 0);
      xfer("t3_rd0", 0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, 0);
      check_val("t3_word0", a_rdata, 32'h0);
      xfer("t3_rd10", 0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 0);
      check_val("t3_word10", a_rdata, 32'hA1B2C3D4);

      xfer("t4_wr", 0, 1'b0, 1'b1, 32'h30, 4'hF, 32'h55AA55AA, 0);
      xfer("t4_ab", 0, 1'b0, 1'b1, 32'h30, 4'hF, 32'hFFFFFFFF, 1);
      xfer("t4_rd", 0, 1'b1, 1'b0, 32'h30, 4'hF, 32'h0, 0);
      check_val("t4_val", a_rdata, 32'h55AA55AA);

      xfer("t5_w0",  1, 1'b0, 1'b1, B_BASE, 4'hF, 32'h11112222, 0);
      xfer("t5_w1",  1, 1'b0, 1'b1, B_BASE + 32'h4, 4'hF, 32'h33334444, 0);
      xfer("t5_r0",  1, 1'b1, 1'b0, B_BASE, 4'h0, 32'h0, 0);
      check_val("t5_val0", b_rdata, 32'h11112222);
      xfer("t5_r1",  1, 1'b1, 1'b0, B_BASE + 32'h4, 4'h0, 32'h0, 0);
      check_val("t5_val1", b_rdata, 32'h33334444);
      xfer("t5_low", 1, 1'b1, 1'b0, B_BASE - 32'h4, 4'hF, 32'h0, 0);
      xfer("t5_rng", 1, 1'b1, 1'b0, B_BASE + 32'(B_DEPTH * 4), 4'hF, 32'h0, 0);
      xfer("t5_wl",  1, 1'b0, 1'b1, B_BASE + 32'(B_DEPTH * 4 - 4), 4'b1001, 32'hCAFEBABE, 0);
      xfer("t5_rl",  1, 1'b1, 1'b0, B_BASE + 32'(B_DEPTH * 4 - 4), 4'hF, 32'h0, 0);
      check_val("t5_vall", b_rdata, 32'hCA0000BE);

      xfer("t6_wr", 0, 1'b0, 1'b1, 32'h40, 4'hF, 32'h0BADF00D, 0);
      xfer("t6_rd", 0, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 0);
      drive(0, 1'b0, 1'b1, 32'h40, 4'hF, 32'hFFFFFFFF);
      @(posedge clk); #1;
      check_val("t6_inwait", {31'd0, a_wreq}, 32'h1);
      @(negedge clk);
      rst = 1'b1;
      drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      @(posedge clk); #1;
      check_reset_outs("t6_rst_a", 0);
      check_reset_outs("t6_rst_b", 1);
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
      @(negedge clk);
      rst = 1'b0;
      xfer("t6_rd2", 0, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 0);
      check_val("t6_val", a_rdata, 32'h0BADF00D);

      for (int i = 0; i < 400; i++) rand_xfer(0);
      for (int i = 0; i < 150; i++) rand_xfer(1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
